mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for alternating grants on contention; otherwise load/store has fixed priority.
module mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_ack_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    output logic                  ls_ack_o,
    output logic [DATA_WIDTH-1:0] ls_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  stall_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic                  r_win_ls;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_ls_rdata;
    logic                  r_if_ack;
    logic                  r_ls_ack;

    logic                  w_grant;
    logic                  w_out_grant;
    logic                  w_sel_ls;
    logic                  w_sel_we;
    logic                  w_cnt_zero;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    assign w_grant    = (r_state == S_IDLE) & (if_req_i | ls_req_i);
    assign w_cnt_zero = (r_cnt == 4'd0);

`ifdef MEM_ARB_RR_EN
    logic r_ptr_ls;

    assign w_sel_ls = ls_req_i & (~if_req_i | r_ptr_ls);

    // Pointer moves toward the loser after every contended grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_ls <= 1'b1;
        end else if (w_grant & if_req_i & ls_req_i) begin
            r_ptr_ls <= ~w_sel_ls;
        end
    end
`else
    assign w_sel_ls = ls_req_i;
`endif

    assign w_sel_we    = w_sel_ls & ls_we_i;
    assign w_sel_addr  = w_sel_ls ? ls_addr_i : if_addr_i;
    assign w_sel_wdata = w_sel_ls ? ls_wdata_i : {DATA_WIDTH{1'b0}};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) w_next_state = S_ACCESS;
                else         w_next_state = S_IDLE;
            end
            S_ACCESS: begin
                if (w_cnt_zero) w_next_state = S_RESP;
                else            w_next_state = S_ACCESS;
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Access operands, latency counter, response capture and ack pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_win_ls   <= 1'b0;
            r_addr     <= {ADDR_WIDTH{1'b0}};
            r_wdata    <= {DATA_WIDTH{1'b0}};
            r_if_rdata <= {DATA_WIDTH{1'b0}};
            r_ls_rdata <= {DATA_WIDTH{1'b0}};
            r_if_ack   <= 1'b0;
            r_ls_ack   <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_cnt    <= LAT_M1;
                        r_we     <= w_sel_we;
                        r_win_ls <= w_sel_ls;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                    end
                end
                S_ACCESS: begin
                    if (w_cnt_zero) begin
                        if (r_win_ls) begin
                            r_ls_ack <= 1'b1;
                            // Stores leave the load data register untouched.
                            if (!r_we) r_ls_rdata <= mem_rdata_i;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= mem_rdata_i;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // The request cycle drives the winner's operands straight through; reset masks them.
    assign w_out_grant = w_grant & ~rst;
    assign mem_req_o   = w_out_grant;
    assign mem_we_o    = w_out_grant ? w_sel_we : ((r_state == S_ACCESS) & r_we);
    assign mem_addr_o  = w_out_grant ? w_sel_addr : r_addr;
    assign mem_wdata_o = w_out_grant ? w_sel_wdata : r_wdata;

    assign if_ack_o   = r_if_ack;
    assign ls_ack_o   = r_ls_ack;
    assign if_rdata_o = r_if_rdata;
    assign ls_rdata_o = r_ls_rdata;
    assign stall_o    = (if_req_i & ~r_if_ack) | (ls_req_i & ~r_ls_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model and a bench-side memory.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int LAT = 2;

    logic          clk;
    logic          rst;
    logic          if_req, if_ack, ls_req, ls_we, ls_ack;
    logic [AW-1:0] if_addr, ls_addr, mem_addr;
    logic [DW-1:0] if_rdata, ls_wdata, ls_rdata, mem_wdata, mem_rdata;
    logic          mem_req, mem_we, stall;

    // Second instance at latency 1
    logic          r1, l1_if_req, l1_if_ack, l1_ls_req, l1_ls_we, l1_ls_ack;
    logic [AW-1:0] l1_if_addr, l1_ls_addr, l1_mem_addr;
    logic [DW-1:0] l1_if_rdata, l1_ls_wdata, l1_ls_rdata, l1_mem_wdata, l1_mem_rdata;
    logic          l1_mem_req, l1_mem_we, l1_stall;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_ack_o(ls_ack), .ls_rdata_o(ls_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .stall_o(stall)
    );

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) u_dut_lat1 (
        .clk(clk), .rst(r1),
        .if_req_i(l1_if_req), .if_addr_i(l1_if_addr), .if_ack_o(l1_if_ack), .if_rdata_o(l1_if_rdata),
        .ls_req_i(l1_ls_req), .ls_we_i(l1_ls_we), .ls_addr_i(l1_ls_addr), .ls_wdata_i(l1_ls_wdata),
        .ls_ack_o(l1_ls_ack), .ls_rdata_o(l1_ls_rdata),
        .mem_req_o(l1_mem_req), .mem_we_o(l1_mem_we), .mem_addr_o(l1_mem_addr),
        .mem_wdata_o(l1_mem_wdata), .mem_rdata_i(l1_mem_rdata), .stall_o(l1_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    bit rand_mode = 1'b0;
    bit hold_mode = 1'b0;
    bit if_done   = 1'b0;
    bit ls_done   = 1'b0;
    int if_ack_cyc;
    int ls_ack_cyc;
    bit ack_order[$];

    // Reference model: an access is a numbered phase since its grant.
    int            m_phase  = 0;
    bit            m_ls     = 1'b0;
    bit            m_we     = 1'b0;
    bit            m_ptr_ls = 1'b1;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [DW-1:0] m_if_rd  = '0;
    logic [DW-1:0] m_ls_rd  = '0;

    // Bench-side memory device.
    bit            d_pend = 1'b0;
    bit            d_we   = 1'b0;
    int            d_cnt  = 0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: called at posedge+1, checks at negedge, advances model at posedge.
    task automatic run_cycle();
        bit            any, wls, e_req, e_we, e_if_ack, e_ls_ack, chk_op, e_stall;
        bit            s_req, s_we;
        logic [AW-1:0] e_addr, s_addr;
        logic [DW-1:0] e_wdata, s_wdata;

        if (if_done) begin if_done = 1'b0; if (!hold_mode) if_req = 1'b0; end
        if (ls_done) begin ls_done = 1'b0; if (!hold_mode) ls_req = 1'b0; end
        if (rand_mode) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h200 + (32'($urandom_range(0, 15)) << 2);
            end
            if (!ls_req && $urandom_range(0, 2) == 0) begin
                ls_req   = 1'b1;
                ls_we    = 1'($urandom_range(0, 1));
                ls_addr  = 32'h200 + (32'($urandom_range(0, 15)) << 2);
                ls_wdata = $urandom;
            end
            rst = ($urandom_range(0, 149) == 0);
        end

        if (rst) begin
            m_phase = 0; m_if_rd = '0; m_ls_rd = '0; m_ptr_ls = 1'b1; d_pend = 1'b0;
        end
        mem_rdata = (d_pend && d_cnt == 0 && !d_we) ? mem_rd(d_addr) : $urandom;

        any = if_req | ls_req;
        wls = 1'b0; e_req = 1'b0; e_we = 1'b0; e_if_ack = 1'b0; e_ls_ack = 1'b0;
        chk_op = 1'b0; e_addr = '0; e_wdata = '0;
        if (rst) begin
            chk_op = 1'b1;
        end else if (m_phase == 0) begin
`ifdef MEM_ARB_RR_EN
            wls = ls_req && (!if_req || m_ptr_ls);
`else
            wls = ls_req;
`endif
            e_req   = any;
            chk_op  = any;
            e_we    = wls && ls_we;
            e_addr  = wls ? ls_addr : if_addr;
            e_wdata = ls_wdata;
        end else if (m_phase <= LAT) begin
            chk_op = 1'b1; e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
        end else begin
            e_ls_ack = m_ls;
            e_if_ack = !m_ls;
        end
        e_stall = (if_req && !e_if_ack) || (ls_req && !e_ls_ack);

        @(negedge clk);
        check_eq("mem_req", 64'(mem_req), 64'(e_req));
        check_eq("mem_we", 64'(mem_we), 64'(e_we));
        if (chk_op) check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
        if (rst || (chk_op && e_we)) check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        check_eq("if_ack", 64'(if_ack), 64'(e_if_ack));
        check_eq("ls_ack", 64'(ls_ack), 64'(e_ls_ack));
        check_eq("if_rdata", 64'(if_rdata), 64'(m_if_rd));
        check_eq("ls_rdata", 64'(ls_rdata), 64'(m_ls_rd));
        check_eq("stall", 64'(stall), 64'(e_stall));
        if (if_ack) begin if_ack_cyc = cyc; ack_order.push_back(1'b0); end
        if (ls_ack) begin ls_ack_cyc = cyc; ack_order.push_back(1'b1); end
        s_req = mem_req; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
        if_done = e_if_ack;
        ls_done = e_ls_ack;

        @(posedge clk);
        if (!rst) begin
            if (d_pend) begin
                if (d_cnt == 0) d_pend = 1'b0;
                else            d_cnt--;
            end
            if (s_req) begin
                d_pend = 1'b1; d_cnt = LAT - 1; d_addr = s_addr; d_we = s_we;
                if (s_we) mem[s_addr] = s_wdata;
            end
            if (m_phase == 0) begin
                if (any) begin
                    m_ls = wls; m_we = e_we; m_addr = e_addr; m_wdata = e_wdata;
                    if (if_req && ls_req) m_ptr_ls = !wls;
                    m_phase = 1;
                end
            end else if (m_phase == LAT + 1) begin
                m_phase = 0;
            end else begin
                if (m_phase == LAT && !m_we) begin
                    if (m_ls) m_ls_rd = mem_rd(m_addr);
                    else      m_if_rd = mem_rd(m_addr);
                end
                m_phase++;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int ack1;
        bit exp_order[4];

        rst = 1'b1; r1 = 1'b1;
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        mem_rdata = '0;
        l1_if_req = 1'b0; l1_if_addr = '0; l1_ls_req = 1'b0; l1_ls_we = 1'b0;
        l1_ls_addr = '0; l1_ls_wdata = '0; l1_mem_rdata = '0;
        @(posedge clk); #1;
        repeat (2) run_cycle();
        rst = 1'b0;
        run_cycle();

        // Single fetch
        mem[32'h100] = 32'hDEAD_BEEF;
        if_addr = 32'h100; if_req = 1'b1; if_ack_cyc = -1; t0 = cyc;
        repeat (6) run_cycle();
        check_eq("fetch_ack_cycle", 64'(if_ack_cyc - t0), 64'd3);
        check_eq("fetch_rdata", 64'(if_rdata), 64'hDEAD_BEEF);

        // Store
        ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h1234_5678; ls_req = 1'b1;
        ls_ack_cyc = -1; t0 = cyc;
        repeat (6) run_cycle();
        check_eq("store_ack_cycle", 64'(ls_ack_cyc - t0), 64'd3);
        check_eq("store_ls_rdata_kept", 64'(ls_rdata), 64'd0);
        check_eq("store_mem_written", 64'(mem_rd(32'h40)), 64'h1234_5678);

        // Fetch and load together
        ls_we = 1'b0; ls_addr = 32'h40; if_addr = 32'h100;
        ls_req = 1'b1; if_req = 1'b1; if_ack_cyc = -1; ls_ack_cyc = -1; t0 = cyc;
        repeat (10) run_cycle();
        check_eq("both_ls_ack_cycle", 64'(ls_ack_cyc - t0), 64'd3);
        check_eq("both_if_ack_cycle", 64'(if_ack_cyc - t0), 64'd7);
        check_eq("both_ls_rdata", 64'(ls_rdata), 64'h1234_5678);

        // Both held for four accesses from a fresh reset
        rst = 1'b1; run_cycle(); rst = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
`else
        exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1; exp_order[3] = 1'b1;
`endif
        ack_order.delete();
        hold_mode = 1'b1; if_req = 1'b1; ls_req = 1'b1;
        repeat (16) run_cycle();
        hold_mode = 1'b0;
        repeat (10) run_cycle();
        check_eq("order_len_ok", 64'(ack_order.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_order.size()) check_eq("grant_order", 64'(ack_order[i]), 64'(exp_order[i]));
        end

        // Reset in the middle of a load
        ls_we = 1'b0; ls_addr = 32'h100; ls_req = 1'b1; ls_ack_cyc = -1; t0 = cyc;
        repeat (2) run_cycle();
        rst = 1'b1; run_cycle(); rst = 1'b0;
        check_eq("abort_no_ack", 64'(ls_ack_cyc), 64'(-1));
        repeat (6) run_cycle();
        check_eq("reserve_ack_cycle", 64'(ls_ack_cyc - t0), 64'd6);
        check_eq("reserve_rdata", 64'(ls_rdata), 64'hDEAD_BEEF);

        // Randomized traffic
        rand_mode = 1'b1;
        repeat (800) run_cycle();
        rand_mode = 1'b0; rst = 1'b0;
        repeat (12) run_cycle();

        // Latency-1 single load
        r1 = 1'b0; l1_ls_req = 1'b1; l1_ls_addr = 32'h80; ack1 = -1;
        for (int k = 0; k < 8; k++) begin
            l1_mem_rdata = (k == 1) ? 32'hCAFE_F00D : $urandom;
            @(negedge clk);
            if (k == 0) check_eq("lat1_mem_req", 64'(l1_mem_req), 64'd1);
            if (l1_ls_ack && ack1 < 0) ack1 = k;
            @(posedge clk); #1;
            if (ack1 >= 0) l1_ls_req = 1'b0;
        end
        check_eq("lat1_ack_cycle", 64'(ack1), 64'd2);
        check_eq("lat1_rdata", 64'(l1_ls_rdata), 64'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
